mem_stage_hs: RTL and testbench
===============================

Name: mem_stage_hs

Overview:
- Parametrised successor to the single-cycle memory stage.
- Talks to an external data memory through a req/ack handshake of variable latency, with byte/halfword/word(/dword) access, little-endian lane steering and sign/zero extension.
- Drives a stall to the hazard detector while an access is outstanding, and flags misaligned or timed-out accesses.
- Sits between the EX/MEM and MEM/WB pipeline registers.

Parameters:
- WORDLENGTH, 32, data/address width; must be 32 or 64. NB = WORDLENGTH/8 byte lanes; LW = log2(NB).
- TIMEOUT, 16, maximum cycles in WAIT before a bus error; must be at least 1.
- TO_W, 5, width of the timeout counter; must satisfy TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- control_signals  in  4  {RegWrite, MemtoReg, MemRead, MemWrite}
- mem_size  in  2  00 byte, 01 half, 10 word, 11 dword (legal only when WORDLENGTH=64)
- mem_signed  in  1  1 = sign-extend loads
- Mem_address  in  WORDLENGTH  ALU result / access address
- Mem_input  in  WORDLENGTH  store data, right-justified
- WB_control  out  2  {RegWrite & ~mem_err, MemtoReg}
- ALU_out  out  WORDLENGTH  = Mem_address, combinational
- Mem_out  out  WORDLENGTH  registered, extended load data
- mem_stall  out  1  freezes the PC, IF/ID, ID/EX and EX/MEM registers
- mem_err  out  1  one-cycle pulse: misaligned, illegal size or timeout
- dmem_req  out  1  registered request
- dmem_we  out  1  registered write enable
- dmem_addr  out  WORDLENGTH  lane-aligned address (low LW bits zero)
- dmem_wdata  out  WORDLENGTH  store data replicated across lanes
- dmem_be  out  NB  byte enables
- dmem_rdata  in  WORDLENGTH  read data, valid when dmem_ack=1
- dmem_ack  in  1  completes the request; ignored outside WAIT

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, Mem_out, timeout counter, mem_err all 0. mem_stall=0.
- access = MemRead | MemWrite. If both are set, treat as illegal: error path, no bus activity.
- Legality check: size bytes S = 1<<mem_size. The access is legal iff Mem_address[log2(S)-1:0]==0 and S<=NB.
- FSM states IDLE, WAIT, DONE.
  - IDLE, access legal: mem_stall=1 combinationally. On the next edge, register dmem_req=1, dmem_we=MemWrite, dmem_addr, dmem_be, dmem_wdata; clear the counter; go to WAIT.
  - IDLE, access illegal: mem_stall=0. mem_err=1 combinationally in this same cycle. WB RegWrite forced to 0. Stay in IDLE; Mem_out unchanged.
  - IDLE, no access: mem_stall=0; outputs hold.
  - WAIT: mem_stall=1; dmem_req and all bus outputs stay stable until ack.
    - dmem_ack=1: dmem_req←0. On a load, Mem_out←extend(dmem_rdata). Go to DONE.
    - No ack and counter==TIMEOUT-1: dmem_req←0, registered mem_err pulse in DONE, go to DONE; Mem_out unchanged.
    - Otherwise: counter+1.
  - DONE: mem_stall=0 for exactly one cycle so the pipeline advances; go to IDLE unconditionally. The same instruction is never re-issued.
- Byte enables: be = ((1<<S)-1) << Mem_address[LW-1:0].
- dmem_wdata: Mem_input[8S-1:0] replicated NB/S times.
- Load extract: field = dmem_rdata >> (8*Mem_address[LW-1:0]), low 8S bits. Sign-extend if mem_signed, else zero-extend. Word/dword loads on a 64-bit bus follow the same rule.
- Minimum access latency: 2 stall cycles (IDLE and WAIT, with ack in the first WAIT cycle), then DONE.
- An asynchronous reset mid-WAIT aborts: dmem_req drops immediately and any later ack is ignored.

Test Plan:
- Word load, WORDLENGTH=32: addr 0x100, ack after 3 WAIT cycles, rdata 0xDEADBEEF → mem_stall high for 4 cycles; Mem_out=0xDEADBEEF in DONE; dmem_be=1111.
- Signed byte load: addr 0x103, rdata 0x80FF_0000, mem_signed=1 → Mem_out=0xFFFFFF80. Same access with mem_signed=0 → 0x00000080.
- Halfword store: addr 0x102, Mem_input 0x1234ABCD → dmem_wdata=0xABCDABCD, dmem_be=1100, dmem_we=1; Mem_out unchanged.
- Misaligned word load at 0x101 → mem_err pulses in that cycle, no dmem_req, WB_control[1]=0, mem_stall=0. Same check for mem_size=11 with WORDLENGTH=32.
- Timeout: ack never arrives, TIMEOUT=16 → dmem_req high 16 cycles, then mem_err pulse in DONE; FSM returns to IDLE; a following access proceeds normally.
- Reset asserted in the 2nd WAIT cycle → dmem_req=0 and state=IDLE immediately; a late dmem_ack causes no Mem_out update.

Source files
------------

// File: rtl/mem_stage_hs.sv
// Memory stage with a variable-latency req/ack data-memory interface, lane steering,
// load extension, pipeline stall generation and misalignment/timeout error reporting.
module mem_stage_hs #(
    parameter int unsigned WORDLENGTH = 32,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned TO_W       = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              control_signals,
    input  logic [1:0]              mem_size,
    input  logic                    mem_signed,
    input  logic [WORDLENGTH-1:0]   Mem_address,
    input  logic [WORDLENGTH-1:0]   Mem_input,
    output logic [1:0]              WB_control,
    output logic [WORDLENGTH-1:0]   ALU_out,
    output logic [WORDLENGTH-1:0]   Mem_out,
    output logic                    mem_stall,
    output logic                    mem_err,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [WORDLENGTH-1:0]   dmem_addr,
    output logic [WORDLENGTH-1:0]   dmem_wdata,
    output logic [WORDLENGTH/8-1:0] dmem_be,
    input  logic [WORDLENGTH-1:0]   dmem_rdata,
    input  logic                    dmem_ack
);

    localparam int unsigned NB = WORDLENGTH / 8;
    localparam int unsigned LW = $clog2(NB);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e                state_q, state_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [WORDLENGTH-1:0] addr_q, addr_d;
    logic [WORDLENGTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0]         be_q, be_d;
    logic [WORDLENGTH-1:0] mem_out_q, mem_out_d;
    logic [TO_W-1:0]       cnt_q, cnt_d;
    logic                  terr_q, terr_d;
    logic [LW-1:0]         off_q, off_d;
    logic [1:0]            size_q, size_d;
    logic                  sgn_q, sgn_d;
    logic                  load_q, load_d;

    logic                  reg_write, mem_to_reg, mem_read, mem_write, access;
    logic [3:0]            size_bytes;
    logic [LW-1:0]         size_mask, offset, lane;
    logic                  legal, start, illegal_hit;
    logic [NB-1:0]         be_calc;
    logic [WORDLENGTH-1:0] wdata_calc, field, load_ext;
    logic                  msb;
    int unsigned           nbits;

    assign reg_write  = control_signals[3];
    assign mem_to_reg = control_signals[2];
    assign mem_read   = control_signals[1];
    assign mem_write  = control_signals[0];
    assign access     = mem_read | mem_write;

    assign size_bytes = 4'd1 << mem_size;
    assign size_mask  = LW'(size_bytes - 4'd1);
    assign offset     = Mem_address[LW-1:0];
    // Read+write together is treated as illegal so no bus cycle is ever started for it.
    assign legal      = (32'(size_bytes) <= NB) && ((offset & size_mask) == '0)
                        && !(mem_read && mem_write);
    assign start       = (state_q == StIdle) && access && legal;
    assign illegal_hit = (state_q == StIdle) && access && !legal;

    assign be_calc = NB'(((16'd1 << size_bytes) - 16'd1) << offset);

    always_comb begin
        wdata_calc = '0;
        lane       = '0;
        for (int i = 0; i < int'(NB); i++) begin
            lane = LW'(i) & size_mask;
            wdata_calc[8*i +: 8] = Mem_input[{lane, 3'b000} +: 8];
        end
    end

    // Extraction uses the offset/size captured at issue, not the live pipeline inputs.
    always_comb begin
        field = dmem_rdata >> {off_q, 3'b000};
        nbits = 32'd8 << size_q;
        case (size_q)
            2'd0:    msb = field[7];
            2'd1:    msb = field[15];
            2'd2:    msb = field[31];
            default: msb = field[WORDLENGTH-1];
        endcase
        load_ext = '0;
        for (int b = 0; b < int'(WORDLENGTH); b++) begin
            load_ext[b] = (32'(b) < nbits) ? field[b] : (sgn_q & msb);
        end
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        mem_out_d = mem_out_q;
        cnt_d     = cnt_q;
        terr_d    = 1'b0;
        off_d     = off_q;
        size_d    = size_q;
        sgn_d     = sgn_q;
        load_d    = load_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    req_d   = 1'b1;
                    we_d    = mem_write;
                    addr_d  = {Mem_address[WORDLENGTH-1:LW], {LW{1'b0}}};
                    be_d    = be_calc;
                    wdata_d = wdata_calc;
                    cnt_d   = '0;
                    off_d   = offset;
                    size_d  = mem_size;
                    sgn_d   = mem_signed;
                    load_d  = mem_read;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (dmem_ack) begin
                    req_d = 1'b0;
                    if (load_q) mem_out_d = load_ext;
                    state_d = StDone;
                end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    terr_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            mem_out_q <= '0;
            cnt_q     <= '0;
            terr_q    <= 1'b0;
            off_q     <= '0;
            size_q    <= '0;
            sgn_q     <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            mem_out_q <= mem_out_d;
            cnt_q     <= cnt_d;
            terr_q    <= terr_d;
            off_q     <= off_d;
            size_q    <= size_d;
            sgn_q     <= sgn_d;
            load_q    <= load_d;
        end
    end

    assign mem_stall  = start || (state_q == StWait);
    assign mem_err    = illegal_hit || terr_q;
    assign WB_control = {reg_write & ~mem_err, mem_to_reg};
    assign ALU_out    = Mem_address;
    assign Mem_out    = mem_out_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed self-checking bench for mem_stage_hs on a 32-bit bus.
module tb_mem_stage_hs;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  control_signals;
    logic [1:0]  mem_size;
    logic        mem_signed;
    logic [31:0] Mem_address, Mem_input;
    logic [1:0]  WB_control;
    logic [31:0] ALU_out, Mem_out;
    logic        mem_stall, mem_err, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;

    int n_checks = 0;
    int n_errors = 0;
    int stalls, reqs;
    logic [3:0]  cap_be;
    logic        cap_we;
    logic [31:0] cap_wdata, cap_addr;

    localparam logic [3:0] CtlLoad  = 4'b1110;
    localparam logic [3:0] CtlStore = 4'b0001;

    mem_stage_hs #(.WORDLENGTH(32), .TIMEOUT(16), .TO_W(5)) dut (
        .clk(clk), .reset(reset), .control_signals(control_signals), .mem_size(mem_size),
        .mem_signed(mem_signed), .Mem_address(Mem_address), .Mem_input(Mem_input),
        .WB_control(WB_control), .ALU_out(ALU_out), .Mem_out(Mem_out),
        .mem_stall(mem_stall), .mem_err(mem_err), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input logic [3:0] ctl, input logic [1:0] sz, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wd);
        control_signals = ctl;
        mem_size        = sz;
        mem_signed      = sgn;
        Mem_address     = addr;
        Mem_input       = wd;
    endtask

    // Entered at posedge+1 of the IDLE cycle with the op driven; leaves at negedge of
    // the first non-stalled cycle. ack_at = WAIT cycle carrying the ack, 0 = never.
    task automatic run_access(input int ack_at, input logic [31:0] rdata,
                              output int n_stall, output int n_req);
        int waits;
        bit ended;
        n_stall = 0;
        n_req   = 0;
        waits   = 0;
        ended   = 1'b0;
        @(negedge clk);
        if (mem_stall) n_stall++;
        for (int c = 0; c < 40 && !ended; c++) begin
            @(posedge clk); #1;
            if (dmem_req) begin
                waits++;
                if (waits == 1) begin
                    cap_be    = dmem_be;
                    cap_we    = dmem_we;
                    cap_wdata = dmem_wdata;
                    cap_addr  = dmem_addr;
                end
            end
            dmem_ack   = (ack_at != 0) && dmem_req && (waits == ack_at);
            dmem_rdata = dmem_ack ? rdata : 32'hA5A5_5A5A;
            @(negedge clk);
            if (dmem_req) n_req++;
            if (mem_stall) n_stall++;
            else ended = 1'b1;
        end
        check_eq("access_bound", 64'(ended), 64'd1);
    endtask

    task automatic next_idle();
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        set_op(4'b0000, 2'd0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        reset      = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        set_op(4'b0000, 2'd0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req", 64'(dmem_req), 64'd0);
        check_eq("rst_stall", 64'(mem_stall), 64'd0);
        check_eq("rst_mem_out", 64'(Mem_out), 64'd0);
        check_eq("rst_err", 64'(mem_err), 64'd0);
        check_eq("rst_be", 64'(dmem_be), 64'd0);
        reset = 1'b1;

        // Word load, ack in the third WAIT cycle
        @(posedge clk); #1;
        set_op(CtlLoad, 2'd2, 1'b0, 32'h0000_0100, 32'h0);
        #1;
        check_eq("lw_idle_stall", 64'(mem_stall), 64'd1);
        check_eq("lw_alu_out", 64'(ALU_out), 64'h100);
        run_access(3, 32'hDEAD_BEEF, stalls, reqs);
        check_eq("lw_stalls", 64'(stalls), 64'd4);
        check_eq("lw_reqs", 64'(reqs), 64'd3);
        check_eq("lw_be", 64'(cap_be), 64'hF);
        check_eq("lw_addr", 64'(cap_addr), 64'h100);
        check_eq("lw_mem_out", 64'(Mem_out), 64'hDEAD_BEEF);
        check_eq("lw_err", 64'(mem_err), 64'd0);
        check_eq("lw_wb", 64'(WB_control), 64'd3);
        next_idle();

        // Signed and unsigned byte loads at lane 3, minimum latency
        set_op(CtlLoad, 2'd0, 1'b1, 32'h0000_0103, 32'h0);
        run_access(1, 32'h80FF_0000, stalls, reqs);
        check_eq("lbs_stalls", 64'(stalls), 64'd2);
        check_eq("lbs_be", 64'(cap_be), 64'b1000);
        check_eq("lbs_mem_out", 64'(Mem_out), 64'hFFFF_FF80);
        next_idle();
        set_op(CtlLoad, 2'd0, 1'b0, 32'h0000_0103, 32'h0);
        run_access(1, 32'h80FF_0000, stalls, reqs);
        check_eq("lbu_mem_out", 64'(Mem_out), 64'h0000_0080);
        next_idle();

        // Halfword store at lane 2
        set_op(CtlStore, 2'd1, 1'b0, 32'h0000_0102, 32'h1234_ABCD);
        run_access(2, 32'h0, stalls, reqs);
        check_eq("sh_wdata", 64'(cap_wdata), 64'hABCD_ABCD);
        check_eq("sh_be", 64'(cap_be), 64'b1100);
        check_eq("sh_we", 64'(cap_we), 64'd1);
        check_eq("sh_addr", 64'(cap_addr), 64'h100);
        check_eq("sh_mem_out", 64'(Mem_out), 64'h0000_0080);
        next_idle();

        // Misaligned word load
        set_op(CtlLoad, 2'd2, 1'b0, 32'h0000_0101, 32'h0);
        #1;
        check_eq("mis_err", 64'(mem_err), 64'd1);
        check_eq("mis_stall", 64'(mem_stall), 64'd0);
        check_eq("mis_wb", 64'(WB_control), 64'b01);
        @(posedge clk); #1;
        check_eq("mis_req", 64'(dmem_req), 64'd0);
        check_eq("mis_mem_out", 64'(Mem_out), 64'h0000_0080);
        // Dword access is illegal on a 32-bit bus
        set_op(CtlLoad, 2'd3, 1'b0, 32'h0000_0100, 32'h0);
        #1;
        check_eq("dw_err", 64'(mem_err), 64'd1);
        check_eq("dw_stall", 64'(mem_stall), 64'd0);
        // Read and write together
        set_op(4'b1011, 2'd2, 1'b0, 32'h0000_0100, 32'h0);
        #1;
        check_eq("rw_err", 64'(mem_err), 64'd1);
        @(posedge clk); #1;
        check_eq("rw_req", 64'(dmem_req), 64'd0);
        set_op(4'b0000, 2'd0, 1'b0, 32'h0, 32'h0);
        #1;
        check_eq("idle_err", 64'(mem_err), 64'd0);

        // Timeout: ack never arrives
        @(posedge clk); #1;
        set_op(CtlLoad, 2'd2, 1'b0, 32'h0000_0200, 32'h0);
        run_access(0, 32'h0, stalls, reqs);
        check_eq("to_reqs", 64'(reqs), 64'd16);
        check_eq("to_stalls", 64'(stalls), 64'd17);
        check_eq("to_err", 64'(mem_err), 64'd1);
        check_eq("to_wb", 64'(WB_control), 64'b01);
        check_eq("to_mem_out", 64'(Mem_out), 64'h0000_0080);
        next_idle();
        #1;
        check_eq("to_err_clear", 64'(mem_err), 64'd0);
        set_op(CtlLoad, 2'd2, 1'b0, 32'h0000_0104, 32'h0);
        run_access(1, 32'h0123_4567, stalls, reqs);
        check_eq("after_to_stalls", 64'(stalls), 64'd2);
        check_eq("after_to_mem_out", 64'(Mem_out), 64'h0123_4567);
        next_idle();

        // Reset during the second WAIT cycle, then a late ack
        set_op(CtlLoad, 2'd2, 1'b0, 32'h0000_0108, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("rw2_req", 64'(dmem_req), 64'd1);
        reset = 1'b0;
        set_op(4'b0000, 2'd0, 1'b0, 32'h0, 32'h0);
        #1;
        check_eq("abort_req", 64'(dmem_req), 64'd0);
        check_eq("abort_stall", 64'(mem_stall), 64'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("late_ack_mem_out", 64'(Mem_out), 64'd0);
        check_eq("late_ack_req", 64'(dmem_req), 64'd0);
        dmem_ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
